// File: rtl/tdm_receive_sync.sv
// TDM serial receiver: oversamples sck/ws/sd in the clk_in domain, tracks frame position
// and lock, and publishes one masked multi-slot sample set per frame.
module tdm_receive_sync #(
  parameter int BIT_WIDTH   = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SLOTS       = 8,
  parameter int FS_DELAY    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             sck_in,
  input  logic                             ws_in,
  input  logic                             sd_in,
  input  logic [SLOTS-1:0]                 slot_en_in,
  output logic [SLOTS-1:0][BIT_WIDTH-1:0]  audio_out,
  output logic                             audio_valid_out,
  output logic                             frame_err_out,
  output logic                             locked_out
);

  localparam int FRAME  = SLOTS * SLOT_WIDTH;
  localparam int PW     = $clog2(FRAME + 1);
  localparam int P_DONE = FS_DELAY + (SLOTS - 1) * SLOT_WIDTH + BIT_WIDTH - 1;

  localparam logic [PW-1:0] FRAME_P = PW'(FRAME);
  localparam logic [PW-1:0] DONE_P  = PW'(P_DONE);
  localparam logic [PW-1:0] FSD_P   = PW'(FS_DELAY);
  localparam logic [PW-1:0] SW_P    = PW'(SLOT_WIDTH);
  localparam logic [PW-1:0] BW_P    = PW'(BIT_WIDTH);

  typedef enum logic {HUNT, RUN} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ws_sync, r_sd_sync;
  logic                   r_sck_prev, r_bit_edge, r_ws_bit, r_sd_bit;

  state_t                          r_state;
  logic [PW-1:0]                   r_pos;
  logic                            r_ws_prev;
  logic [SLOTS-1:0][BIT_WIDTH-1:0] r_shadow;

  logic                            w_fs, w_hit;
  logic [PW-1:0]                   w_cur, w_off, w_slot;
  logic [PW:0]                     w_off_x;
  logic [SLOTS-1:0][BIT_WIDTH-1:0] w_shadow_next, w_shadow_restart, w_frame;

  // Edge, ws and sd are registered together so the FSM sees one coherent bit sample.
  // NOTE: every sequential block uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_prev <= 1'b0;
      r_bit_edge <= 1'b0;
      r_ws_bit   <= 1'b0;
      r_sd_bit   <= 1'b0;
    end else begin
      r_sck_sync <= SYNC_STAGES'({r_sck_sync, sck_in});
      r_ws_sync  <= SYNC_STAGES'({r_ws_sync, ws_in});
      r_sd_sync  <= SYNC_STAGES'({r_sd_sync, sd_in});
      r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
      r_bit_edge <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
      r_ws_bit   <= r_ws_sync[SYNC_STAGES-1];
      r_sd_bit   <= r_sd_sync[SYNC_STAGES-1];
    end
  end

  assign w_fs    = r_ws_bit & ~r_ws_prev;
  assign w_cur   = r_pos + PW'(1);
  assign w_off_x = {1'b0, w_cur} - {1'b0, FSD_P};
  assign w_off   = w_off_x[PW-1:0];
  assign w_slot  = w_off / SW_P;
  assign w_hit   = !w_off_x[PW] && (w_off < FRAME_P) && ((w_off % SW_P) < BW_P);

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    w_shadow_next    = r_shadow;
    w_shadow_restart = '0;
    w_frame          = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (w_hit && (w_slot == PW'(s)))
        w_shadow_next[s] = (r_shadow[s] << 1) | BIT_WIDTH'(r_sd_bit);
      w_frame[s] = slot_en_in[s] ? w_shadow_next[s] : '0;
    end
    // With no frame-sync delay the frame-start edge already carries slot-0 MSB.
    if (FS_DELAY == 0)
      w_shadow_restart[0] = BIT_WIDTH'(r_sd_bit);
  end

  // NOTE: the shadow and output frames are reset explicitly; nothing may leak across a reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state         <= HUNT;
      r_pos           <= '0;
      r_ws_prev       <= 1'b0;
      r_shadow        <= '0;
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
      frame_err_out   <= 1'b0;
      locked_out      <= 1'b0;
    end else begin
      audio_valid_out <= 1'b0;
      frame_err_out   <= 1'b0;
      if (r_bit_edge) begin
        r_ws_prev <= r_ws_bit;
        case (r_state)
          HUNT: begin
            if (w_fs) begin
              r_state  <= RUN;
              r_pos    <= '0;
              r_shadow <= w_shadow_restart;
            end
          end
          RUN: begin
            if (w_fs) begin
              r_pos    <= '0;
              r_shadow <= w_shadow_restart;
              if (w_cur == FRAME_P) begin
                locked_out <= 1'b1;
                if (DONE_P == FRAME_P) begin
                  audio_out       <= w_frame;
                  audio_valid_out <= 1'b1;
                end
              end else begin
                frame_err_out <= 1'b1;
                locked_out    <= 1'b0;
              end
            end else if (w_cur == FRAME_P) begin
              frame_err_out <= 1'b1;
              locked_out    <= 1'b0;
              r_state       <= HUNT;
              r_pos         <= '0;
            end else begin
              r_pos    <= w_cur;
              r_shadow <= w_shadow_next;
              if (w_cur == DONE_P) begin
                audio_out       <= w_frame;
                audio_valid_out <= 1'b1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/tdm_receive_sync.md
# tdm_receive_sync

Parametrised successor to the TDM microphone receiver. It runs entirely in the system clock domain and oversamples the TDM serial bus (sck/ws/sd) through synchronisers. It supports configurable slot width, slot count, frame-sync delay and a per-slot enable mask. It double-buffers the captured frame, tracks frame lock, flags framing errors, and feeds the beamforming datapath one complete multi-channel sample set per frame.

## Interface
- BIT_WIDTH, 24: audio bits captured per slot, MSB first; must be ≤ SLOT_WIDTH.
- SLOT_WIDTH, 32: sck edges per slot; the trailing SLOT_WIDTH−BIT_WIDTH bits are ignored.
- SLOTS, 8: slots per frame, 1..16.
- FS_DELAY, 1: sck edges from the frame-start edge to slot-0 MSB; legal values 0 or 1.
- SYNC_STAGES, 2: synchroniser flops on sck_in, ws_in and sd_in.
- clk_in  input  1  system clock (100 MHz); must be ≥ 4× sck_in frequency.
- rst_in  input  1  asynchronous, active-high reset.
- sck_in  input  1  serial clock (asynchronous to clk_in).
- ws_in  input  1  frame sync.
- sd_in  input  1  serial data.
- slot_en_in  input  SLOTS  per-slot enable; bit s enables slot s.
- audio_out  output  [BIT_WIDTH-1:0] × SLOTS  last complete frame, stable between valid pulses.
- audio_valid_out  output  1  one-clk_in pulse when audio_out updates.
- frame_err_out  output  1  one-clk_in pulse on a framing error.
- locked_out  output  1  high while frames arrive at the correct spacing.

## Operation
- sck_in, ws_in and sd_in each pass through SYNC_STAGES flops. A "bit edge" is one clk_in cycle in which synchronised sck goes 0→1. ws and sd are sampled only on bit edges.
- Frame start: a bit edge where sampled ws = 1 and ws sampled at the previous bit edge = 0. A level held high does not produce another frame start.
- Position counter pos: set to 0 on a frame-start edge, incremented on every other bit edge. F = SLOTS·SLOT_WIDTH.
- Capture: the bit at pos = FS_DELAY + s·SLOT_WIDTH + k, for k < BIT_WIDTH, shifts into shadow[s] (MSB first). All other positions are ignored.
- States:
  - HUNT (reset state): ignore data; on frame start go to RUN with pos = 0 and shadow cleared.
  - RUN: capture as above.
    - Completion edge, pos = FS_DELAY + (SLOTS−1)·SLOT_WIDTH + BIT_WIDTH − 1: copy shadow to audio_out, with slots where slot_en_in[s] = 0 forced to 0. slot_en_in is sampled on this cycle. Pulse audio_valid_out.
    - Frame start at pos = F: correct spacing; set locked_out; restart the frame. When FS_DELAY = 1 and BIT_WIDTH = SLOT_WIDTH, this same edge also carries the final data bit. That bit is captured first, completion fires, and then the frame restarts.
    - Frame start at pos ≠ F (early): pulse frame_err_out, clear locked_out, discard the partial frame (no valid pulse), restart at pos = 0 in RUN.
    - pos reaches F without a frame start (late/missing): pulse frame_err_out, clear locked_out, go to HUNT.
- audio_out holds its previous value through errors. It changes only on a completion edge or on reset.
- Reset (asynchronous, any time): audio_out all 0, audio_valid_out 0, frame_err_out 0, locked_out 0, state HUNT, pos 0, shadow 0, synchronisers and ws history 0. After reset, a fresh ws rising edge is required before any capture.

## Timing
- Edge-detect latency: a raw sck_in rise is seen as a bit edge SYNC_STAGES+1 clk_in cycles later.
- audio_out and audio_valid_out update on the clk_in edge after the completion bit edge is detected: SYNC_STAGES+2 cycles after the raw sck rise.
- frame_err_out and locked_out changes have the same latency relative to the offending bit edge.
- audio_valid_out and frame_err_out are each exactly one clk_in cycle wide. They never assert in the same cycle, because completion and error edges are distinct.
- locked_out first rises on the second correctly spaced frame start after HUNT.

## Test plan
- Defaults; slot s carries 0xA00000+s; three frames with ws pulsing at pos F → one valid pulse per frame, audio_out[s] = 0xA00000+s, locked_out = 1 from the second frame start, frame_err_out never asserts.
- slot_en_in = 8'b0000_0101, same data → audio_out[0] = 0xA00000, audio_out[2] = 0xA00002, all other slots 0.
- Early ws rise at pos 100 in frame 2 → single frame_err_out pulse, locked_out falls, no valid for the partial frame, audio_out keeps frame-1 data; the next full frame pulses valid.
- ws withheld at pos 256 → frame_err_out pulse, HUNT, no valid pulses until the next ws rise; that frame then captures correctly.
- rst_in asserted asynchronously mid-frame at pos 50 → all outputs 0 before the next clk_in edge, no valid for that frame, normal capture after release plus a ws rise.
- FS_DELAY = 0, BIT_WIDTH = SLOT_WIDTH = 16, SLOTS = 4, slot data 0x1234/0x5678/0x9ABC/0xDEF0 → exact values captured, valid pulses once per 64-edge frame.
